hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage RISC-V core. Decides each cycle whether the PC and the IF/ID, ID/EX and later stage registers advance, freeze, or are flushed. It covers load-use stalls, taken-branch flushes and multi-cycle data-memory waits with a timeout. It sits beside the forwarding unit in the Processor top and drives the write/flush enables of PC and all pipeline registers.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before the error state; legal range 1..255.
- CNT_W, 16: width of the performance counters.

Ports:
- Clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IF_ID_rs1  in  5  rs1 field of the instruction in ID.
- IF_ID_rs2  in  5  rs2 field of the instruction in ID.
- IF_ID_uses_rs2  in  1  ID instruction reads rs2 (R/S/B types).
- ID_EX_rd  in  5  rd of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- MEM_req  in  1  instruction in MEM performs a data-memory access.
- MEM_ready  in  1  data memory completes the access this cycle.
- PC_write  out  1  PC loads pc_next.
- IF_ID_write  out  1  IF/ID register loads.
- IF_ID_flush  out  1  IF/ID loads a NOP.
- ID_EX_bubble  out  1  ID/EX loads a NOP (all control bits zero).
- pipe_hold  out  1  EX/MEM and MEM/WB hold; WB write suppressed.
- mem_err  out  1  sticky memory-timeout error.
- ctrl_state  out  2  current state: 0 RUN, 1 MEM_WAIT, 2 ERROR.
- stall_count  out  CNT_W  stall-cycle counter.
- flush_count  out  CNT_W  taken-branch flush counter.

## Operation
- State machine: RUN, MEM_WAIT, ERROR. ctrl_state encodes it directly.
- RUN defaults: PC_write=1, IF_ID_write=1, all others 0.
- Memory wait in RUN: when MEM_req=1 and MEM_ready=0:
  - pipe_hold=1, PC_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=0.
  - Branch and load-use evaluation is suppressed.
  - Next state is MEM_WAIT; wait_cnt loads 1.
- Taken branch in RUN (no memory wait): IF_ID_flush=1, ID_EX_bubble=1, PC_write=1.
  - Takes priority over load-use, because the ID instruction is discarded.
- Load-use in RUN (no memory wait, no taken branch):
  - Condition: ID_EX_MemRead=1, ID_EX_rd≠0, and (rd==rs1 or (IF_ID_uses_rs2 and rd==rs2)).
  - Response: PC_write=0, IF_ID_write=0, ID_EX_bubble=1.
  - Exactly one bubble per load; forwarding resolves the dependency on the next cycle.
- MEM_WAIT: outputs are the same as a memory wait in RUN while MEM_ready=0.
  - Each cycle wait_cnt increments.
  - When wait_cnt==MEM_TIMEOUT with MEM_ready=0, next state is ERROR.
  - When MEM_ready=1, outputs revert to RUN evaluation in the same cycle (branch and load-use are evaluated normally), and next state is RUN.
- ERROR: PC_write=0, IF_ID_write=0, pipe_hold=1, mem_err=1.
  - Exits only via reset.
- rd=x0 never triggers a stall.

## Timing
- All outputs except ctrl_state, mem_err and the counters are combinational (Mealy) from inputs and state: zero-cycle latency.
- State, wait_cnt, mem_err and the counters update on the rising Clk edge.
- Reset asserted (reset=0), asynchronously:
  - state=RUN, wait_cnt=0, mem_err=0, counters=0.
  - Outputs forced to PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_bubble=1, pipe_hold=0, ctrl_state=0.
- Reset asserted mid-MEM_WAIT or in ERROR returns immediately to the reset values above; no pending hold survives.
- A memory wait of N cycles costs exactly N hold cycles.
- A request with MEM_ready=1 on its first cycle costs 0 hold cycles and never enters MEM_WAIT.
- Simultaneous load-use and taken branch: flush only; no stall cycle.
- Simultaneous MEM_ready=1 and wait_cnt==MEM_TIMEOUT: ready wins and the FSM returns to RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_count increments on every cycle with PC_write=0 outside reset.
  - flush_count increments on every cycle with a taken-branch flush.
  - Both counters saturate at all-ones.
- HAZARD_PERF_CNT_EN undefined: the counter logic is absent and stall_count and flush_count are tied to 0.

## Test plan
- Load-use on rs1: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs1=5 -> one cycle of PC_write=0, IF_ID_write=0, ID_EX_bubble=1; normal on the next cycle.
- Load to x0, and a rs2 match with IF_ID_uses_rs2=0 (ID_EX_rd=7, IF_ID_rs2=7) -> no stall in either case.
- Taken branch together with load-use: EX_branch_taken=1 plus the load-use condition -> IF_ID_flush=1, ID_EX_bubble=1, PC_write=1; flush_count +1; stall_count unchanged.
- MEM_req=1 with MEM_ready low for 3 cycles, then high -> pipe_hold=1 for exactly 3 cycles; ctrl_state 0->1->1->1->0; stall_count +3.
- Timeout: MEM_TIMEOUT=4, MEM_ready held 0 -> ERROR after 5 hold cycles total; mem_err=1 sticky. Pulsing reset low mid-ERROR gives ctrl_state=0, mem_err=0 and the reset output values immediately.
- Build without HAZARD_PERF_CNT_EN and repeat the previous scenario -> stall_count and flush_count stay 0.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Sequencing bundle between the hazard controller and the pipeline datapath.
// master = datapath side, slave = hazard_controller.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_rs1;
    logic [4:0]       IF_ID_rs2;
    logic             IF_ID_uses_rs2;
    logic [4:0]       ID_EX_rd;
    logic             ID_EX_MemRead;
    logic             EX_branch_taken;
    logic             MEM_req;
    logic             MEM_ready;
    logic             PC_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             pipe_hold;
    logic             mem_err;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2,
        output ID_EX_rd, ID_EX_MemRead, EX_branch_taken,
        output MEM_req, MEM_ready,
        input  PC_write, IF_ID_write, IF_ID_flush,
        input  ID_EX_bubble, pipe_hold, mem_err,
        input  ctrl_state, stall_count, flush_count
    );

    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2,
        input  ID_EX_rd, ID_EX_MemRead, EX_branch_taken,
        input  MEM_req, MEM_ready,
        output PC_write, IF_ID_write, IF_ID_flush,
        output ID_EX_bubble, pipe_hold, mem_err,
        output ctrl_state, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline advance/freeze/flush controller: load-use, taken branch, memory wait.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush counters.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic               Clk,
    input logic               reset,
    hazard_controller_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       mem_err_q;

    logic pc_write, ifid_write, ifid_flush, idex_bubble, hold;
    logic br_flush, load_use;
    logic in_rst, in_err, in_wait, go, do_br, do_lu;

    assign load_use = hz.ID_EX_MemRead && (hz.ID_EX_rd != 5'd0) &&
                      ((hz.ID_EX_rd == hz.IF_ID_rs1) ||
                       (hz.IF_ID_uses_rs2 && (hz.ID_EX_rd == hz.IF_ID_rs2)));

    // Mutually exclusive priority terms so the decoder below is truly unique.
    assign in_rst  = !reset;
    assign in_err  = reset && (state == ERROR);
    assign in_wait = reset && (state != ERROR) && !hz.MEM_ready &&
                     ((state == MEM_WAIT) || hz.MEM_req);
    assign go      = reset && (state != ERROR) && !in_wait;
    assign do_br   = go && hz.EX_branch_taken;
    assign do_lu   = go && !hz.EX_branch_taken && load_use;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        hold        = 1'b0;
        br_flush    = 1'b0;
        state_nxt   = RUN;
        wait_nxt    = 8'd0;
        unique case (1'b1)
            in_rst: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            in_err: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                hold       = 1'b1;
                state_nxt  = ERROR;
            end
            in_wait: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                hold       = 1'b1;
                if (state == RUN) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = 8'd1;
                end else if (wait_cnt >= TIMEOUT) begin
                    state_nxt = ERROR;
                    wait_nxt  = wait_cnt;
                end else begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = wait_cnt + 8'd1;
                end
            end
            do_br: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                br_flush    = 1'b1;
            end
            do_lu: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            default: begin
                pc_write = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            mem_err_q <= mem_err_q | (state_nxt == ERROR);
        end
    end

    assign hz.PC_write     = pc_write;
    assign hz.IF_ID_write  = ifid_write;
    assign hz.IF_ID_flush  = ifid_flush;
    assign hz.ID_EX_bubble = idex_bubble;
    assign hz.pipe_hold    = hold;
    assign hz.mem_err      = mem_err_q;
    assign hz.ctrl_state   = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (br_flush && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.stall_count = stall_q;
    assign hz.flush_count = flush_q;
`else
    assign hz.stall_count = '0;
    assign hz.flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with MEM_TIMEOUT=4.
// Counter expectations follow HAZARD_PERF_CNT_EN (zero when undefined).
module tb_hazard_controller;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic Clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   es = 0;
    int   ef = 0;

    hazard_controller_if #(.CNT_W(16)) hz ();

    hazard_controller #(
        .MEM_TIMEOUT(4),
        .CNT_W      (16)
    ) dut (
        .Clk  (Clk),
        .reset(reset),
        .hz   (hz)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {hz.PC_write, hz.IF_ID_write, hz.IF_ID_flush,
                hz.ID_EX_bubble, hz.pipe_hold};
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd,
                         input logic mr, input logic br,
                         input logic req, input logic rdy);
        @(negedge Clk);
        hz.IF_ID_rs1       = rs1;
        hz.IF_ID_rs2       = rs2;
        hz.IF_ID_uses_rs2  = u2;
        hz.ID_EX_rd        = rd;
        hz.ID_EX_MemRead   = mr;
        hz.EX_branch_taken = br;
        hz.MEM_req         = req;
        hz.MEM_ready       = rdy;
        #1;
    endtask

    // exp = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold}
    task automatic step(input string tag, input logic [4:0] exp,
                        input logic [1:0] st);
        check({tag, "_stallcnt"}, 32'(hz.stall_count), PERF ? es : 0);
        check({tag, "_flushcnt"}, 32'(hz.flush_count), PERF ? ef : 0);
        check({tag, "_outs"}, 32'(outs()), 32'(exp));
        check({tag, "_state"}, 32'(hz.ctrl_state), 32'(st));
        check({tag, "_memerr"}, 32'(hz.mem_err), (st == 2'd2) ? 1 : 0);
        if (!exp[4]) es++;
        if (exp == 5'b11110) ef++;
    endtask

    initial begin
        reset              = 1'b0;
        hz.IF_ID_rs1       = '0;
        hz.IF_ID_rs2       = '0;
        hz.IF_ID_uses_rs2  = 1'b0;
        hz.ID_EX_rd        = '0;
        hz.ID_EX_MemRead   = 1'b0;
        hz.EX_branch_taken = 1'b0;
        hz.MEM_req         = 1'b0;
        hz.MEM_ready       = 1'b0;

        @(posedge Clk);
        #1;
        check("rst_outs", 32'(outs()), 32'(5'b00110));
        check("rst_state", 32'(hz.ctrl_state), 0);
        check("rst_memerr", 32'(hz.mem_err), 0);
        check("rst_stallcnt", 32'(hz.stall_count), 0);
        check("rst_flushcnt", 32'(hz.flush_count), 0);
        @(negedge Clk);
        reset = 1'b1;

        drive(0, 0, 0, 0, 0, 0, 0, 0); step("idle", 5'b11000, 0);
        drive(5, 0, 0, 5, 1, 0, 0, 0); step("lu_rs1", 5'b00010, 0);
        drive(5, 0, 0, 5, 0, 0, 0, 0); step("lu_after", 5'b11000, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0); step("ld_x0", 5'b11000, 0);
        drive(3, 7, 0, 7, 1, 0, 0, 0); step("rs2_unused", 5'b11000, 0);
        drive(3, 7, 1, 7, 1, 0, 0, 0); step("lu_rs2", 5'b00010, 0);
        drive(7, 0, 0, 7, 1, 1, 0, 0); step("br_lu", 5'b11110, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step("post_br", 5'b11000, 0);

        drive(0, 0, 0, 0, 0, 0, 1, 0); step("mw3_a", 5'b00001, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0); step("mw3_b", 5'b00001, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0); step("mw3_c", 5'b00001, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 1); step("mw3_rdy", 5'b11000, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step("mw3_done", 5'b11000, 0);

        drive(0, 0, 0, 0, 0, 0, 1, 1); step("rdy_first", 5'b11000, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step("rdy_after", 5'b11000, 0);

        drive(0, 0, 0, 0, 0, 0, 1, 0); step("mwbr_a", 5'b00001, 0);
        drive(7, 0, 0, 7, 1, 1, 1, 1); step("mwbr_rdy", 5'b11110, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step("mwbr_done", 5'b11000, 0);

        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            step("edge_hold", 5'b00001, (i == 0) ? 2'd0 : 2'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1); step("edge_rdy", 5'b11000, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step("edge_done", 5'b11000, 0);

        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            step("to_hold", 5'b00001, (i == 0) ? 2'd0 : 2'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0); step("to_err", 5'b00001, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 1); step("to_sticky", 5'b00001, 2);

        #1;
        reset = 1'b0;
        es = 0;
        ef = 0;
        #1;
        check("errrst_outs", 32'(outs()), 32'(5'b00110));
        check("errrst_state", 32'(hz.ctrl_state), 0);
        check("errrst_memerr", 32'(hz.mem_err), 0);
        check("errrst_stallcnt", 32'(hz.stall_count), 0);
        check("errrst_flushcnt", 32'(hz.flush_count), 0);
        @(negedge Clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0); step("post_rst", 5'b11000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
